// File: rtl/dm_access_module.sv
// M-stage data-memory responder: one load/store per handshake against a word-wide RAM,
// with byte/half/word store placement, load extension and address-error reporting.
module dm_access_module #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam int unsigned DEPTH     = 1 << (ADDR_W - 2);
  localparam logic [2:0]  WAIT_LAST = 3'(WAIT_CYC);

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       ld_word;
  logic [31:0]       ram [DEPTH];

  logic [5:0]  op_in;
  logic        is_mem_in;
  logic        mis_in;
  logic        err_in;
  logic        accept;
  logic        is_load_q;
  logic        is_store_q;
  logic        last_cyc;
  logic        mem_we;
  logic [3:0]  be;
  logic [31:0] lane_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;
  logic [ADDR_W-3:0] widx;
  logic        unused_ok;

  assign op_in     = instr[31:26];
  assign unused_ok = ^instr[25:0];

  always_comb begin
    is_mem_in = 1'b0;
    mis_in    = 1'b0;
    case (op_in)
      OP_LB, OP_LBU, OP_SB: is_mem_in = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        is_mem_in = 1'b1;
        mis_in    = addr[0];
      end
      OP_LW, OP_SW: begin
        is_mem_in = 1'b1;
        mis_in    = (addr[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  assign err_in     = mis_in | (addr[31:ADDR_W] != '0);
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  // Non-memory ops complete the handshake but never leave IDLE.
  assign accept     = req_valid && req_ready && is_mem_in;

  assign is_load_q  = (op_q[5:3] == 3'b100);
  assign is_store_q = (op_q[5:3] == 3'b101);
  assign last_cyc   = (state == ACCESS) && (cnt == WAIT_LAST);
  assign mem_we     = last_cyc && is_store_q;
  assign widx       = addr_q[ADDR_W-1:2];

  always_comb begin
    be        = '0;
    lane_data = wdata_q;
    case (op_q)
      OP_SB: begin
        be        = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      OP_SW: be = '1;
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = 8'(ld_word >> {addr_q[1:0], 3'b000});
    half_sel = addr_q[1] ? ld_word[31:16] : ld_word[15:0];
    case (op_q)
      OP_LB:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_ext = {24'h000000, byte_sel};
      OP_LH:   ld_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_ext = {16'h0000, half_sel};
      default: ld_ext = ld_word;
    endcase
  end

  // Write enable is derived from state, so an asynchronous reset cancels a pending store.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) ram[widx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      ld_word  <= '0;
      done     <= 1'b0;
      rdata    <= '0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
    end else begin
      done     <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            addr_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            err_q   <= err_in;
            cnt     <= '0;
            state   <= err_in ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (last_cyc) begin
            if (is_load_q) ld_word <= ram[widx];
            state <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          done <= 1'b1;
          if (err_q) begin
            exc_adel <= is_load_q;
            exc_ades <= is_store_q;
          end else if (is_load_q) begin
            rdata <= ld_ext;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_module.sv
// Scoreboard bench for dm_access_module: two instances (WAIT_CYC 0 and 3) driven by directed vectors.
module tb_dm_access_module;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        busy      [2];
  logic        done      [2];
  logic        exc_adel  [2];
  logic        exc_ades  [2];
  logic [31:0] instr     [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dm_access_module #(.ADDR_W(12), .WAIT_CYC((g == 0) ? 0 : 3)) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .instr     (instr[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .rdata     (rdata[g]),
      .exc_adel  (exc_adel[g]),
      .exc_ades  (exc_ades[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    int          lat;
    time         t_acc;
  } exp_t;

  exp_t        q0 [$];
  exp_t        q1 [$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mdl_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst_n === 1'b1 && done[d] === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done dut%0d: got done=1 expected done=0", d);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("rdata_dut%0d", d), rdata[d], e.rdata);
          check($sformatf("exc_adel_dut%0d", d), {31'b0, exc_adel[d]}, {31'b0, e.adel});
          check($sformatf("exc_ades_dut%0d", d), {31'b0, exc_ades[d]}, {31'b0, e.ades});
          check($sformatf("latency_dut%0d", d), 32'(($time - e.t_acc - 5) / 10), 32'(e.lat));
        end
      end
    end
  end

  // req_valid is held until done is seen, so requests presented while busy must be ignored.
  task automatic xfer(input int d, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic adel, input logic ades);
    exp_t e;
    int   nb;
    bit   seen;
    @(negedge clk);
    check($sformatf("ready_dut%0d", d), {31'b0, req_ready[d]}, 32'd1);
    instr[d]     = {op, 26'h0};
    addr[d]      = a;
    wdata[d]     = wd;
    req_valid[d] = 1'b1;
    @(posedge clk);
    e.t_acc = $time;
    e.rdata = exp_rd;
    e.adel  = adel;
    e.ades  = ades;
    e.lat   = (adel | ades) ? 1 : ((d == 0) ? 2 : 5);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    mdl_rd[d] = exp_rd;
    nb   = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done[d] === 1'b1) seen = 1;
      else if (busy[d] === 1'b1) nb++;
    end
    req_valid[d] = 1'b0;
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout dut%0d: got no done expected done within 20 cycles", d);
    end
    check($sformatf("busy_cycles_dut%0d", d), 32'(nb), 32'(e.lat));
  endtask

  task automatic st(input int d, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    xfer(d, op, a, wd, mdl_rd[d], 1'b0, 1'b0);
  endtask

  task automatic ld(input int d, input logic [5:0] op, input logic [31:0] a, input logic [31:0] exp_rd);
    xfer(d, op, a, 32'h0, exp_rd, 1'b0, 1'b0);
  endtask

  task automatic ld_err(input int d, input logic [5:0] op, input logic [31:0] a);
    xfer(d, op, a, 32'h0, mdl_rd[d], 1'b1, 1'b0);
  endtask

  task automatic st_err(input int d, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    xfer(d, op, a, wd, mdl_rd[d], 1'b0, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      instr[d]     = '0;
      addr[d]      = '0;
      wdata[d]     = '0;
      mdl_rd[d]    = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", {31'b0, req_ready[d]}, 32'd1);
      check("reset_busy",  {31'b0, busy[d]},      32'd0);
      check("reset_done",  {31'b0, done[d]},      32'd0);
      check("reset_rdata", rdata[d],              32'h0);
      check("reset_exc",   {30'b0, exc_adel[d], exc_ades[d]}, 32'd0);
    end
    rst_n = 1'b1;

    // word store/load, then byte and half placement with extension
    st(0, OP_SW, 32'h10, 32'h8899AABB);
    ld(0, OP_LW, 32'h10, 32'h8899AABB);
    st(0, OP_SB, 32'h11, 32'h000000F0);
    ld(0, OP_LW, 32'h10, 32'h8899F0BB);
    ld(0, OP_LB, 32'h11, 32'hFFFFFFF0);
    ld(0, OP_LBU, 32'h11, 32'h000000F0);
    st(0, OP_SH, 32'h12, 32'h00001234);
    ld(0, OP_LH, 32'h12, 32'h00001234);
    ld(0, OP_LHU, 32'h10, 32'h0000F0BB);
    ld(0, OP_LH, 32'h10, 32'hFFFFF0BB);
    ld(0, OP_LB, 32'h13, 32'h00000012);
    ld(0, OP_LW, 32'h10, 32'h1234F0BB);

    // address errors
    ld_err(0, OP_LW, 32'h13);
    st(0, OP_SW, 32'h14, 32'hCAFEBABE);
    st_err(0, OP_SH, 32'h15, 32'h0000FFFF);
    ld(0, OP_LW, 32'h14, 32'hCAFEBABE);
    ld_err(0, OP_LW, 32'h1000);
    ld_err(0, OP_LHU, 32'h21);
    st_err(0, OP_SW, 32'h22, 32'h01020304);

    // wait-state instance
    st(1, OP_SW, 32'h40, 32'hA5A55A5A);
    ld(1, OP_LW, 32'h40, 32'hA5A55A5A);
    ld(1, OP_LH, 32'h42, 32'hFFFFA5A5);
    st(1, OP_SB, 32'h40, 32'h00000080);
    ld(1, OP_LBU, 32'h40, 32'h00000080);
    ld(1, OP_LW, 32'h40, 32'hA5A55A80);
    ld_err(1, OP_LW, 32'h41);

    // reset aborts a store in flight
    st(0, OP_SW, 32'h20, 32'h11223344);
    ld(0, OP_LW, 32'h20, 32'h11223344);
    @(negedge clk);
    instr[0]     = {OP_SW, 26'h0};
    addr[0]      = 32'h20;
    wdata[0]     = 32'hDEADBEEF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'b0, busy[0]}, 32'd1);
    rst_n        = 1'b0;
    req_valid[0] = 1'b0;
    mdl_rd[0]    = '0;
    mdl_rd[1]    = '0;
    @(negedge clk);
    check("abort_busy",  {31'b0, busy[0]}, 32'd0);
    check("abort_done",  {31'b0, done[0]}, 32'd0);
    check("abort_rdata", rdata[0],         32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_done", {31'b0, done[0]}, 32'd0);
    ld(0, OP_LW, 32'h20, 32'h11223344);

    // non-memory op is swallowed
    @(negedge clk);
    instr[0]     = 32'h00851021;
    addr[0]      = 32'h20;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nonmem_busy", {31'b0, busy[0]}, 32'd0);
      check("nonmem_done", {31'b0, done[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;
    ld(0, OP_LBU, 32'h23, 32'h00000011);

    repeat (4) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
